// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector with show-ahead FIFO and valid/ready output.
// Optional macro PARITY_EN adds a trailing even-parity bit per word.
//
// Ports:
//   clk, reset      clock (rising edge) and async active-high reset
//   sync            restart frame, drop partial word
//   bit_valid       bit_in is qualified this cycle
//   bit_in          serial data bit
//   msb_first       bit order, latched on the first bit of each word
//   word_valid      FIFO head valid
//   word_data       FIFO head word, 0 when empty
//   word_ready      consumer accepts head
//   fifo_count      number of stored words
//   overflow        sticky dropped-word flag
//   clear_ovf       clear overflow
//   parity_err      one-cycle pulse on parity mismatch (PARITY_EN only)
module serial_word_collector #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sync,
  input  logic                     bit_valid,
  input  logic                     bit_in,
  input  logic                     msb_first,
  output logic                     word_valid,
  output logic [WIDTH-1:0]         word_data,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clear_ovf,
  output logic                     parity_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CONE  = CW'(1);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PONE  = AW'(1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, COLLECT} state_t;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  asm_q, asm_d;
  logic              dir_q, dir_d;
  logic [AW-1:0]     rd_q, wr_q;
  logic [AW:0]       fcnt_q;
  logic              ovf_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              dir;
  logic [WIDTH-1:0]  shifted;
  logic [WIDTH-1:0]  push_word;
  logic              push;
  logic              pop;
  logic              full;
  logic              wr_en;
  logic              drop;

  // First bit of a word uses the live msb_first; later bits the latched one.
  assign dir     = (state_q == IDLE) ? msb_first : dir_q;
  assign shifted = dir ? {asm_q[WIDTH-2:0], bit_in}
                       : {bit_in, asm_q[WIDTH-1:1]};

`ifdef PARITY_EN
  logic perr_q, perr_d;
  assign push_word  = asm_q;
  assign parity_err = perr_q;
`else
  assign push_word  = shifted;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    dir_d   = dir_q;
    push    = 1'b0;
`ifdef PARITY_EN
    perr_d  = 1'b0;
`endif
    if (sync) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          dir_d   = msb_first;
          asm_d   = shifted;
          cnt_d   = CONE;
          state_d = COLLECT;
        end
        COLLECT: begin
          asm_d = shifted;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
`ifdef PARITY_EN
            state_d = PARITY;
`else
            push    = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CONE;
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          state_d = IDLE;
          if (^{asm_q, bit_in}) perr_d = 1'b1;
          else                  push   = 1'b1;
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign word_valid = (fcnt_q != '0);
  assign word_data  = word_valid ? mem_q[rd_q] : '0;
  assign fifo_count = fcnt_q;
  assign overflow   = ovf_q;

  assign pop   = word_valid && word_ready;
  assign full  = (fcnt_q == FULL);
  // A pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      dir_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      fcnt_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      dir_q   <= dir_d;
`ifdef PARITY_EN
      perr_q  <= perr_d;
`endif
      if (wr_en) wr_q <= wr_q + PONE;
      if (pop)   rd_q <= rd_q + PONE;
      if (wr_en && !pop)      fcnt_q <= fcnt_q + FONE;
      else if (!wr_en && pop) fcnt_q <= fcnt_q - FONE;
      // A new drop wins over a same-cycle clear.
      ovf_q <= drop || (ovf_q && !clear_ovf);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_word;
  end

endmodule
